// File: rtl/alu_op_sequencer_if.sv
// Operand/control bundle between the issue stage and the ALU execute sequencer.
// master = issue side (drives opcode/operands/flush), slave = sequencer.
interface alu_op_sequencer_if;
  logic        flush;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  opcode;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] a_alu;
  logic [31:0] b_alu;
  logic [12:0] alu_signals;
  logic        result_valid;
  logic        flags_we;
  logic        stall;
  logic        div_by_zero;
  logic        illegal_op;

  modport master (
    output flush, op_valid, opcode, a_in, b_in,
    input  op_ready, a_alu, b_alu, alu_signals, result_valid, flags_we,
           stall, div_by_zero, illegal_op
  );

  modport slave (
    input  flush, op_valid, opcode, a_in, b_in,
    output op_ready, a_alu, b_alu, alu_signals, result_valid, flags_we,
           stall, div_by_zero, illegal_op
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Execute-stage sequencer: decodes SimpleRISC opcodes to one-hot ALU control and holds
// operands/control for 1, MUL_LAT or DIV_LAT cycles; stalls upstream via op_ready; flushable.
module alu_op_sequencer #(
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 4
) (
  input logic              clk,
  input logic              reset,
  alu_op_sequencer_if.slave bus
);
  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT - 1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [12:0] r_alu_sig;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_illegal;

  logic [12:0]   w_dec;
  logic [CW-1:0] w_cnt_init;
  logic          w_undef;
  logic          w_last;
  logic          w_ready;
  logic          w_accept;
  logic          w_result;

  always_comb begin
    w_dec      = '0;
    w_cnt_init = '0;
    w_undef    = 1'b0;
    case (bus.opcode)
      5'b00000, 5'b01110, 5'b01111: w_dec[0] = 1'b1;  // ld/st reuse add for address
      5'b00001: w_dec[1] = 1'b1;
      5'b00010: begin w_dec[3] = 1'b1; w_cnt_init = MUL_CNT; end
      5'b00011: begin w_dec[4] = 1'b1; w_cnt_init = DIV_CNT; end
      5'b00100: begin w_dec[5] = 1'b1; w_cnt_init = DIV_CNT; end
      5'b00101: w_dec[2]  = 1'b1;
      5'b00110: w_dec[10] = 1'b1;
      5'b00111: w_dec[9]  = 1'b1;
      5'b01000: w_dec[11] = 1'b1;
      5'b01001: w_dec[12] = 1'b1;
      5'b01010: w_dec[6]  = 1'b1;
      5'b01011: w_dec[7]  = 1'b1;
      5'b01100: w_dec[8]  = 1'b1;
      5'b01101, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10100: ;
      default:  w_undef = 1'b1;
    endcase
  end

  // A killed op never reports a result, even if flush lands on its final cycle.
  assign w_last   = (r_state == EXEC) && (r_cnt == '0);
  assign w_ready  = ~bus.flush & ((r_state == IDLE) | w_last);
  assign w_accept = bus.op_valid & w_ready;
  assign w_result = w_last & ~bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_alu_sig <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_illegal <= 1'b0;
    end else if (bus.flush) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_alu_sig <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_accept & w_undef;
      if (w_accept && (|w_dec)) begin
        r_state   <= EXEC;
        r_cnt     <= w_cnt_init;
        r_alu_sig <= w_dec;
        r_a       <= bus.a_in;
        r_b       <= bus.b_in;
      end else if ((r_state == EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_state   <= IDLE;
        r_alu_sig <= '0;
      end
    end
  end

  assign bus.op_ready     = w_ready;
  assign bus.stall        = bus.op_valid & ~w_ready;
  assign bus.a_alu        = r_a;
  assign bus.b_alu        = r_b;
  assign bus.alu_signals  = r_alu_sig;
  assign bus.result_valid = w_result;
  assign bus.flags_we     = w_result & r_alu_sig[2];
  assign bus.div_by_zero  = w_result & (r_alu_sig[4] | r_alu_sig[5]) & (r_b == 32'd0);
  assign bus.illegal_op   = r_illegal;
endmodule
